rnd_vec_pipe: RTL and testbench
===============================

RND_VEC_PIPE -- requirements
Module: rnd_vec_pipe

Interface
REQ-001 SHALL have parameter width_i, default 24, input augmented mantissa width per lane.
REQ-002 SHALL have parameter width_o, default 4, output mantissa width per lane; legal range 2 <= width_o < width_i, with width_i-width_o <= 32.
REQ-003 SHALL have parameter lanes, default 4, number of parallel rounding lanes.
REQ-004 i_clk  input  1  single clock; all state on rising edge.
REQ-005 i_rst  input  1  reset, synchronous, active-high.
REQ-006 i_valid  input  1  input beat valid.
REQ-007 o_ready  output  1  block accepts beat when i_valid&&o_ready.
REQ-008 i_mode  input  2  rounding mode for the beat: 0 truncate, 1 nearest-even, 2 stochastic, 3 half-up.
REQ-009 i_num  input  lanes*width_i  lane k at bits [k*width_i +: width_i], unsigned.
REQ-010 i_seed_load  input  1  single-cycle pulse loading LFSR seed.
REQ-011 i_seed  input  32  seed value.
REQ-012 o_valid  output  1  output beat valid.
REQ-013 i_ready  input  1  downstream accepts when o_valid&&i_ready.
REQ-014 o_man  output  lanes*width_o  rounded mantissa, lane k at [k*width_o +: width_o].
REQ-015 o_ofl  output  lanes  per-lane overflow flag.

Function
REQ-016 Per lane, d = width_i-width_o; kept K = top width_o bits, discarded D = low d bits, half H = 2^(d-1).
REQ-017 Round-up u: mode 0 u=0; mode 1 u=(D>H)||(D==H&&K[0]); mode 2 u=carry-out of D+R, R = low d bits of lane LFSR; mode 3 u=(D>=H).
REQ-018 If u=0: o_man=K, o_ofl=0; if u=1 and K<all-ones: o_man=K+1, o_ofl=0.
REQ-019 If u=1 and K==all-ones: o_man=1<<(width_o-1) (renormalised), o_ofl=1.
REQ-020 Two-stage pipeline: S1 registers i_num, i_mode and per-lane R; S2 registers o_man/o_ofl/o_valid.
REQ-021 Latency: beat accepted on cycle n appears with o_valid=1 on cycle n+2 when not stalled.
REQ-022 S2 advances when !o_valid||i_ready; S1 advances when S2 advances or S2 empty; o_ready = !s1_valid || S1 advances (combinational).
REQ-023 Full throughput 1 beat/cycle with i_ready held high; no beat dropped, duplicated or reordered under any backpressure.
REQ-024 o_man/o_ofl SHALL hold stable while o_valid=1 and i_ready=0.
REQ-025 Each lane owns a 32-bit Fibonacci LFSR, polynomial x^32+x^22+x^2+x+1, advancing one step per accepted beat regardless of mode.
REQ-026 Accepted beat samples the current LFSR state as R; state never zero.
REQ-027 i_seed_load: lane k LFSR loads i_seed^(k+1), or 1 if that is zero; load wins over same-cycle advance; beat accepted same cycle uses pre-load state.
REQ-028 Mode is captured per beat; mode changes between beats take effect without bubbles.

Reset
REQ-029 i_rst=1 SHALL, on the next edge, clear S1/S2 valid, set o_valid=0, o_man=0, o_ofl=0.
REQ-030 Reset SHALL load lane k LFSR with 32'hACE10000+k+1; reset wins over i_seed_load and input acceptance.
REQ-031 During reset o_ready=0; after deassertion o_ready=1 next cycle; in-flight beats are discarded.

Verification (bench: width_i=8, width_o=4, lanes=2)
REQ-032 Mode 1: i_num lanes {0x58,0x48} -> o_man {6,4}; 0x49 -> 5; o_ofl 0; o_valid two cycles after accept.
REQ-033 Mode 0 0x4F -> 4; mode 3 0x48 -> 5; mode 1/3 0xF8 -> o_man 0x8, o_ofl 1; mode 0 0xFF -> 0xF, o_ofl 0.
REQ-034 Mode 2, D=4 (i_num 0x44), 4096 beats -> round-up fraction 0.25+-0.03; D=0 never rounds up; seed reload reproduces identical sequence.
REQ-035 Stream 8 beats, i_ready low cycles 3-7 -> o_ready low after S1/S2 fill, all 8 outputs delivered in order, outputs stable while stalled.
REQ-036 Assert i_rst mid-stream with 2 beats in flight -> o_valid 0 next cycle, in-flight beats never emitted, LFSR equals reset values.

Source files
------------

// File: rtl/rnd_vec_pipe.sv
// Multi-lane mantissa rounder: truncate / nearest-even / stochastic (per-lane LFSR) / half-up.
// Latency 2 cycles (S1 capture, S2 round+register); 1 beat/cycle with downstream ready.
// Backpressure: valid/ready skid-free pipeline, o_ready drops only when both stages are full and stalled.
module rnd_vec_pipe #(
    parameter int width_i = 24,
    parameter int width_o = 4,
    parameter int lanes   = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [1:0]                 i_mode,
    input  logic [lanes*width_i-1:0]   i_num,
    input  logic                       i_seed_load,
    input  logic [31:0]                i_seed,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [lanes*width_o-1:0]   o_man,
    output logic [lanes-1:0]           o_ofl
);

    localparam int dw = width_i - width_o;
    localparam logic [dw-1:0]      half   = dw'(1 << (dw - 1));
    localparam logic [width_o-1:0] renorm = {1'b1, {(width_o-1){1'b0}}};
    localparam logic [width_o-1:0] one_o  = {{(width_o-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        MODE_TRUNC  = 2'd0,
        MODE_RNE    = 2'd1,
        MODE_STOCH  = 2'd2,
        MODE_HALFUP = 2'd3
    } mode_e;

    typedef struct packed {
        mode_e                       mode;
        logic [lanes-1:0][dw-1:0]    rnd;
        logic [lanes*width_i-1:0]    num;
    } beat_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    // A zero seed would lock the register, so it is replaced by 1.
    function automatic logic [31:0] lane_seed(input logic [31:0] s, input int k);
        logic [31:0] v;
        v = s ^ 32'(k + 1);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

    logic                      s1_valid;
    beat_t                     s1_q;
    logic                      s2_adv;
    logic                      accept;
    logic [lanes-1:0][31:0]    lfsr;
    logic [lanes*width_o-1:0]  rnd_man;
    logic [lanes-1:0]          rnd_ofl;

    assign s2_adv  = !o_valid || i_ready;
    assign o_ready = !i_rst && (!s1_valid || s2_adv);
    assign accept  = i_valid && o_ready;

    // Load takes priority over the advance; an accepted beat has already sampled the old state.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < lanes; k++) begin
            if (i_rst)
                lfsr[k] <= 32'hACE1_0000 + 32'(k + 1);
            else if (i_seed_load)
                lfsr[k] <= lane_seed(i_seed, k);
            else if (accept)
                lfsr[k] <= lfsr_step(lfsr[k]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            s1_valid <= 1'b0;
        else if (o_ready)
            s1_valid <= i_valid;
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            s1_q.mode <= mode_e'(i_mode);
            s1_q.num  <= i_num;
            for (int k = 0; k < lanes; k++)
                s1_q.rnd[k] <= lfsr[k][dw-1:0];
        end
    end

    for (genvar k = 0; k < lanes; k++) begin : g_lane
        logic [width_o-1:0] kept;
        logic [dw-1:0]      disc;
        logic [dw:0]        sum;
        logic               up;

        assign kept = s1_q.num[k*width_i+dw +: width_o];
        assign disc = s1_q.num[k*width_i +: dw];
        assign sum  = {1'b0, disc} + {1'b0, s1_q.rnd[k]};

        always_comb begin
            up = 1'b0;
            case (s1_q.mode)
                MODE_TRUNC:  up = 1'b0;
                MODE_RNE:    up = (disc > half) || ((disc == half) && kept[0]);
                MODE_STOCH:  up = sum[dw];
                MODE_HALFUP: up = (disc >= half);
                default:     up = 1'b0;
            endcase
        end

        // Carry out of an all-ones mantissa renormalises to 1.000... and flags overflow.
        assign rnd_man[k*width_o +: width_o] = !up      ? kept   :
                                               (&kept)  ? renorm : kept + one_o;
        assign rnd_ofl[k] = up && (&kept);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_man   <= '0;
            o_ofl   <= '0;
        end else if (s2_adv) begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_man <= rnd_man;
                o_ofl <= rnd_ofl;
            end
        end
    end

endmodule

// File: tb/tb_rnd_vec_pipe.sv
// Randomised and directed checks of rnd_vec_pipe (width_i=8, width_o=4, lanes=2) against a queue-based reference model.
module tb_rnd_vec_pipe;

    localparam int WI = 8;
    localparam int WO = 4;
    localparam int L  = 2;

    logic            clk = 1'b0;
    logic            i_rst, i_valid, o_ready, i_seed_load, o_valid, i_ready;
    logic [1:0]      i_mode;
    logic [L*WI-1:0] i_num;
    logic [31:0]     i_seed;
    logic [L*WO-1:0] o_man;
    logic [L-1:0]    o_ofl;

    always #5 clk = ~clk;

    rnd_vec_pipe #(.width_i(WI), .width_o(WO), .lanes(L)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_mode(i_mode), .i_num(i_num), .i_seed_load(i_seed_load), .i_seed(i_seed),
        .o_valid(o_valid), .i_ready(i_ready), .o_man(o_man), .o_ofl(o_ofl)
    );

    typedef struct {
        logic [L*WO-1:0] man;
        logic [L-1:0]    ofl;
        int              cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [9:0]  cap_q[$];
    logic [9:0]  cap1[$];
    logic [31:0] lfsr_m[L];
    int          n_vec = 0, n_err = 0, cyc_n = 0, n_up = 0;
    bit          acc, lat_chk, cap_en, stall_prev;
    logic [L*WO-1:0] held_man;
    logic [L-1:0]    held_ofl;

    logic [1:0]  dir_mode[8];
    logic [15:0] dir_num[8];
    logic [9:0]  dir_exp[8];
    logic [15:0] rnum[32];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, expv, cyc_n);
        end
    endtask

    function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
        return {s[30:0], ^(s & 32'h8020_0003)};
    endfunction

    // Returns {ofl, man} for one lane, straight from the rounding rules.
    function automatic logic [4:0] ref_round(input logic [1:0] mode, input logic [7:0] x, input logic [31:0] st);
        int kk, dd, rr;
        bit up;
        kk = int'(x) / 16;
        dd = int'(x) % 16;
        rr = int'(st[3:0]);
        case (mode)
            2'd0:    up = 0;
            2'd1:    up = (dd > 8) || (dd == 8 && (kk % 2) == 1);
            2'd2:    up = (dd + rr) >= 16;
            default: up = (dd >= 8);
        endcase
        if (!up)       return {1'b0, 4'(kk)};
        else if (kk < 15) return {1'b0, 4'(kk + 1)};
        else           return {1'b1, 4'd8};
    endfunction

    // Called at a falling edge; models the coming rising edge.
    task automatic tick();
        exp_t e;
        logic [4:0] r;
        #1;
        acc = i_valid && o_ready;
        if (stall_prev) begin
            check_eq("hold_vld", 32'(o_valid), 32'd1);
            check_eq("hold_man", 32'(o_man), 32'(held_man));
            check_eq("hold_ofl", 32'(o_ofl), 32'(held_ofl));
        end
        if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_vld", 32'(o_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("man", 32'(o_man), 32'(e.man));
                check_eq("ofl", 32'(o_ofl), 32'(e.ofl));
                if (lat_chk) check_eq("latency", 32'(cyc_n - e.cyc), 32'd2);
                if (cap_en) cap_q.push_back({o_ofl, o_man});
                for (int k = 0; k < L; k++)
                    if (o_man[k*WO +: WO] == 4'd5) n_up++;
            end
        end
        if (i_rst) begin
            exp_q.delete();
            for (int k = 0; k < L; k++) lfsr_m[k] = 32'hACE1_0000 + 32'(k + 1);
        end else begin
            if (acc) begin
                e.cyc = cyc_n;
                for (int k = 0; k < L; k++) begin
                    r = ref_round(i_mode, i_num[k*WI +: WI], lfsr_m[k]);
                    e.man[k*WO +: WO] = r[3:0];
                    e.ofl[k] = r[4];
                end
                exp_q.push_back(e);
            end
            for (int k = 0; k < L; k++) begin
                if (i_seed_load) begin
                    lfsr_m[k] = i_seed ^ 32'(k + 1);
                    if (lfsr_m[k] == 32'd0) lfsr_m[k] = 32'd1;
                end else if (acc) begin
                    lfsr_m[k] = lfsr_adv(lfsr_m[k]);
                end
            end
        end
        stall_prev = o_valid && !i_ready && !i_rst;
        held_man = o_man;
        held_ofl = o_ofl;
        @(posedge clk);
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic drain();
        i_valid = 0;
        i_ready = 1;
        i_seed_load = 0;
        for (int t = 0; t < 20 && exp_q.size() > 0; t++) tick();
        tick();
        check_eq("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic seed_load(input logic [31:0] s);
        i_valid = 0;
        i_seed_load = 1;
        i_seed = s;
        tick();
        i_seed_load = 0;
    endtask

    initial begin
        int sent;
        bit ordy_low;
        logic [31:0] sd;

        dir_mode = '{2'd1, 2'd1, 2'd0, 2'd3, 2'd1, 2'd3, 2'd0, 2'd1};
        dir_num  = '{16'h4858, 16'h4949, 16'h4F4F, 16'h4848, 16'hF8F8, 16'hF8F8, 16'hFFFF, 16'hF800};
        dir_exp  = '{10'h046, 10'h055, 10'h044, 10'h055, 10'h388, 10'h388, 10'h0FF, 10'h280};

        i_rst = 1; i_valid = 0; i_mode = 0; i_num = 0;
        i_seed_load = 0; i_seed = 0; i_ready = 0;
        lat_chk = 0; cap_en = 0; stall_prev = 0;
        @(negedge clk);
        tick();
        tick();
        check_eq("rst_ovld", 32'(o_valid), 32'd0);
        check_eq("rst_man", 32'(o_man), 32'd0);
        check_eq("rst_ofl", 32'(o_ofl), 32'd0);
        check_eq("rst_ordy", 32'(o_ready), 32'd0);
        i_rst = 0;
        tick();
        check_eq("post_rst_ordy", 32'(o_ready), 32'd1);

        // Directed rounding cases, back to back with a mode change every beat.
        lat_chk = 1; cap_en = 1; i_ready = 1;
        cap_q.delete();
        for (int i = 0; i < 8; i++) begin
            i_valid = 1; i_mode = dir_mode[i]; i_num = dir_num[i];
            tick();
        end
        drain();
        check_eq("dir_cnt", 32'(cap_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < cap_q.size(); i++)
            check_eq($sformatf("dir%0d", i), 32'(cap_q[i]), 32'(dir_exp[i]));
        cap_en = 0;

        // Stochastic statistics with D = 4 and D = 0.
        n_up = 0;
        for (int i = 0; i < 4096; i++) begin
            i_valid = 1; i_mode = 2'd2; i_num = 16'h4444;
            tick();
        end
        drain();
        check_eq("sr_frac", 32'(n_up >= 1802 && n_up <= 2294), 32'd1);
        n_up = 0;
        for (int i = 0; i < 256; i++) begin
            i_valid = 1; i_mode = 2'd2; i_num = 16'h4040;
            tick();
        end
        drain();
        check_eq("sr_d0_up", 32'(n_up), 32'd0);

        // Seed reload must reproduce the same stochastic sequence.
        sd = $urandom;
        for (int i = 0; i < 32; i++) rnum[i] = 16'($urandom);
        for (int pass = 0; pass < 2; pass++) begin
            cap_q.delete();
            cap_en = 1;
            seed_load(sd);
            for (int i = 0; i < 32; i++) begin
                i_valid = 1; i_mode = 2'd2; i_num = rnum[i];
                tick();
            end
            drain();
            cap_en = 0;
            if (pass == 0) cap1 = cap_q;
        end
        check_eq("reseed_cnt", 32'(cap_q.size()), 32'd32);
        for (int i = 0; i < 32 && i < cap_q.size() && i < cap1.size(); i++)
            check_eq("reseed", 32'(cap_q[i]), 32'(cap1[i]));

        // Seeds that xor to zero in one lane.
        seed_load(32'd1);
        for (int i = 0; i < 16; i++) begin
            i_valid = 1; i_mode = 2'd2; i_num = 16'($urandom);
            tick();
        end
        drain();

        // Stall window: ready low for cycles 3..7 of an 8-beat stream.
        lat_chk = 0; sent = 0; ordy_low = 0;
        for (int t = 0; t < 40 && (sent < 8 || exp_q.size() > 0); t++) begin
            i_ready = !(t >= 3 && t <= 7);
            i_valid = (sent < 8);
            i_mode = 2'($urandom);
            i_num = 16'($urandom);
            tick();
            if (acc) sent++;
            else if (i_valid) ordy_low = 1;
        end
        check_eq("stall_sent", 32'(sent), 32'd8);
        check_eq("stall_ordy_low", 32'(ordy_low), 32'd1);
        check_eq("stall_drain", 32'(exp_q.size()), 32'd0);

        // Random traffic with random backpressure and occasional reseeds.
        for (int t = 0; t < 1500; t++) begin
            i_valid = ($urandom % 4) != 0;
            i_ready = ($urandom % 3) != 0;
            i_mode = 2'($urandom);
            i_num = 16'($urandom);
            i_seed_load = ($urandom % 50) == 0;
            case ($urandom % 3)
                0:       i_seed = 32'd1;
                1:       i_seed = 32'd2;
                default: i_seed = $urandom;
            endcase
            tick();
        end
        drain();

        // Reset with two beats in flight.
        i_ready = 0;
        for (int i = 0; i < 2; i++) begin
            i_valid = 1; i_mode = 2'd1; i_num = 16'($urandom);
            tick();
        end
        check_eq("inflight", 32'(exp_q.size()), 32'd2);
        i_rst = 1; i_valid = 1;
        tick();
        check_eq("mrst_ovld", 32'(o_valid), 32'd0);
        check_eq("mrst_ordy", 32'(o_ready), 32'd0);
        i_rst = 0; i_valid = 0; i_ready = 1;
        for (int i = 0; i < 4; i++) tick();
        check_eq("mrst_ordy1", 32'(o_ready), 32'd1);
        lat_chk = 1;
        for (int i = 0; i < 64; i++) begin
            i_valid = 1; i_mode = 2'd2; i_num = 16'($urandom);
            tick();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
